shift_sum_pipe: RTL and testbench



---
 rtl/shift_sum_pkg.sv | 20 ++
 rtl/shift_stage_chain.sv | 23 ++
 rtl/shift_sum_pipe.sv | 104 ++++++++++
 tb/tb_shift_sum_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_sum_pkg.sv
// Shared constants for the shift/sum pipeline.
//   - Default geometry (WIDTH, DEPTH, CNT_W).
//   - sum_w(): window-sum width that cannot overflow for DEPTH full-scale samples.
//   - Per-edge operation codes, listed in priority order (clear beats accept beats hold).
package shift_sum_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 4;

    localparam logic [1:0] OP_HOLD   = 2'd0;
    localparam logic [1:0] OP_ACCEPT = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;

    // DEPTH is a power of two, so DEPTH*(2^WIDTH-1) fits in WIDTH+log2(DEPTH) bits.
    function automatic int sum_w(input int width, input int depth);
        return width + $clog2(depth);
    endfunction

endpackage

// File: rtl/shift_stage_chain.sv
// WIDTH x DEPTH register chain.
//   clk, rst (sync, active-low) ; shift_en moves d into stage 0 and every stage
//   one place older ; clear zeroes all stages (below reset, above shift_en).
//   stages[0] is the newest sample, stages[DEPTH-1] the oldest.
module shift_stage_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        shift_en,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            d,
    output logic [DEPTH-1:0][WIDTH-1:0] stages
);

    always_ff @(posedge clk) begin
        if (!rst)          stages <= '0;
        else if (clear)    stages <= '0;
        else if (shift_en) stages <= {stages[DEPTH-2:0], d};
    end

endmodule

// File: rtl/shift_sum_pipe.sv
// DEPTH-stage shift pipeline with running window sum, fill indicator and
// wrapping sample counter.
//   clk, rst      : clock, synchronous active-low reset
//   in_valid, in  : sample strobe and data
//   clear         : flush stages/sum/fill (q keeps counting history)
//   R1, RN        : newest and oldest stage
//   out           : sum of all stages (SUM_W bits, never wraps)
//   full          : DEPTH samples accepted since reset/clear
//   q             : accepted-sample count modulo 2^CNT_W
//   avg           : out >> log2(DEPTH); present only when AVG_OUT_EN is defined
module shift_sum_pipe
    import shift_sum_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int SUM_W = sum_w(WIDTH, DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic             clear,
    output logic [WIDTH-1:0] R1,
    output logic [WIDTH-1:0] RN,
    output logic [SUM_W-1:0] out,
    output logic             full,
    output logic [CNT_W-1:0] q
`ifdef AVG_OUT_EN
    ,
    output logic [WIDTH-1:0] avg
`endif
);

    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int LOG2D  = $clog2(DEPTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [1:0]                   op;
    logic [DEPTH-1:0][WIDTH-1:0]  stages;
    logic [FILL_W-1:0]            fill;
    logic [FILL_W-1:0]            fill_next;
    logic [SUM_W-1:0]             sum_next;

    always_comb begin
        op = OP_HOLD;
        if (clear)         op = OP_CLEAR;
        else if (in_valid) op = OP_ACCEPT;
    end

    shift_stage_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chain (
        .clk      (clk),
        .rst      (rst),
        .shift_en (op == OP_ACCEPT),
        .clear    (op == OP_CLEAR),
        .d        (in),
        .stages   (stages)
    );

    assign R1 = stages[0];
    assign RN = stages[DEPTH-1];

    // Oldest sample leaves the window as the new one enters; the intermediate
    // never goes negative because out already contains the outgoing sample.
    assign sum_next  = out + SUM_W'(in) - SUM_W'(stages[DEPTH-1]);
    assign fill_next = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            out  <= '0;
            fill <= '0;
            full <= 1'b0;
            q    <= '0;
        end else begin
            case (op)
                OP_CLEAR: begin
                    out  <= '0;
                    fill <= '0;
                    full <= 1'b0;
                end
                OP_ACCEPT: begin
                    out  <= sum_next;
                    fill <= fill_next;
                    full <= (fill_next == FILL_MAX);
                    q    <= q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef AVG_OUT_EN
    // Registered alongside out so both describe the same window.
    always_ff @(posedge clk) begin
        if (!rst)                  avg <= '0;
        else if (op == OP_CLEAR)   avg <= '0;
        else if (op == OP_ACCEPT)  avg <= sum_next[SUM_W-1:LOG2D];
    end
`endif

endmodule

// File: tb/tb_shift_sum_pipe.sv
// Randomised + directed bench for shift_sum_pipe (default geometry).
// Each stimulus edge pushes the reference model's view into a queue; a
// monitor pops one entry per clock and compares against the DUT outputs.
module tb_shift_sum_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int SUM_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] R1, RN;
    logic [SUM_W-1:0] out;
    logic             full;
    logic [CNT_W-1:0] q;
`ifdef AVG_OUT_EN
    logic [WIDTH-1:0] avg;
`endif

    shift_sum_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in       (in),
        .clear    (clear),
        .R1       (R1),
        .RN       (RN),
        .out      (out),
        .full     (full),
        .q        (q)
`ifdef AVG_OUT_EN
        ,
        .avg      (avg)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int r1, rn, sum, full, q, avg;
    } exp_t;

    exp_t exp_q[$];
    int   win[$];     // samples currently in the window, oldest first
    int   cnt = 0;    // accepted samples since reset (unbounded)
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model_view();
        exp_t e;
        e.sum = 0;
        foreach (win[i]) e.sum += win[i];
        e.r1   = (win.size() > 0) ? win[win.size()-1] : 0;
        e.rn   = (win.size() == DEPTH) ? win[0] : 0;
        e.full = (win.size() == DEPTH) ? 1 : 0;
        e.q    = cnt % (1 << CNT_W);
        e.avg  = e.sum / DEPTH;
        return e;
    endfunction

    // One clock edge with the given inputs; model follows the priority rules.
    task automatic step(input bit r_n, input bit clr, input bit v, input int d);
        rst = r_n; clear = clr; in_valid = v; in = WIDTH'(d);
        @(posedge clk);
        if (!r_n) begin
            win.delete();
            cnt = 0;
        end else if (clr) begin
            win.delete();
        end else if (v) begin
            win.push_back(d);
            if (win.size() > DEPTH) void'(win.pop_front());
            cnt++;
        end
        exp_q.push_back(model_view());
        #2;  // let the monitor compare this edge before the next drive
    endtask

    task automatic accept(input int d);
        step(1'b1, 1'b0, 1'b1, d);
    endtask

    // Monitor: one scoreboard entry per clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_out",  int'(out),  e.sum);
                chk("sb_R1",   int'(R1),   e.r1);
                chk("sb_RN",   int'(RN),   e.rn);
                chk("sb_full", int'(full), e.full);
                chk("sb_q",    int'(q),    e.q);
`ifdef AVG_OUT_EN
                chk("sb_avg",  int'(avg),  e.avg);
`endif
            end
        end
    end

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0, 0);
        chk("rst_out", int'(out), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_full", int'(full), 0);

        // Window fill
        accept(11); accept(22); accept(33);
        chk("fill3_out", int'(out), 66);
        chk("fill3_full", int'(full), 0);
        accept(44);
        chk("fill4_out", int'(out), 110);
        chk("fill4_R1", int'(R1), 44);
        chk("fill4_RN", int'(RN), 11);
        chk("fill4_full", int'(full), 1);
        chk("fill4_q", int'(q), 4);

        accept(55);
        chk("slide_out", int'(out), 154);
        chk("slide_RN", int'(RN), 22);
        chk("slide_R1", int'(R1), 55);
        chk("slide_q", int'(q), 5);
`ifdef AVG_OUT_EN
        chk("slide_avg", int'(avg), 38);
`endif

        // Full-scale window: no overflow
        repeat (4) accept(255);
        chk("max_out", int'(out), 1020);
`ifdef AVG_OUT_EN
        chk("max_avg", int'(avg), 255);
`endif

        // Gap: everything frozen
        repeat (5) step(1'b1, 1'b0, 1'b0, $urandom_range(0, 255));
        chk("gap_out", int'(out), 1020);
        chk("gap_q", int'(q), 9);
        chk("gap_full", int'(full), 1);
        accept(1);
        chk("resume_out", int'(out), 766);
        chk("resume_RN", int'(RN), 255);

        // Clear with simultaneous valid sample
        step(1'b0, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 6; i++) accept(i * 3);
        step(1'b1, 1'b1, 1'b1, 99);
        chk("clr_out", int'(out), 0);
        chk("clr_R1", int'(R1), 0);
        chk("clr_full", int'(full), 0);
        chk("clr_q", int'(q), 6);
        accept(7);
        chk("postclr_out", int'(out), 7);
        chk("postclr_q", int'(q), 7);

        // Counter wrap, then reset mid-stream
        step(1'b0, 1'b0, 1'b0, 0);
        repeat (17) accept($urandom_range(0, 255));
        chk("wrap_q", int'(q), 1);
        step(1'b0, 1'b1, 1'b1, 200);
        chk("midrst_out", int'(out), 0);
        chk("midrst_R1", int'(R1), 0);
        chk("midrst_q", int'(q), 0);
        accept(9);
        chk("postrst_q", int'(q), 1);
        chk("postrst_full", int'(full), 0);
        chk("postrst_out", int'(out), 9);

        // Random traffic: mostly accepts, occasional gaps, clears and resets
        for (int i = 0; i < 400; i++) begin
            int  r;
            bit  r_n, clr, v;
            r   = $urandom_range(0, 99);
            r_n = (r >= 2);
            clr = (r >= 2 && r < 6);
            v   = ($urandom_range(0, 3) != 0);
            step(r_n, clr, v, $urandom_range(0, 255));
        end

        @(posedge clk); #2;
        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
